if_byte_fetch: RTL and testbench

Instruction-fetch stage directly upstream of the decode stage. It assembles one 32-bit RISC-V instruction from a byte-wide, 1-cycle-latency memory port as four little-endian byte reads. It then presents {pc, inst, valid} to the IF/ID boundary and holds it until consumed. It also handles redirects from execute and yields the memory port when the memory stage owns it.

---
 rtl/if_byte_fetch.sv | 135 +++++++++++++
 tb/tb_if_byte_fetch.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/if_byte_fetch.sv
// Instruction fetch over a byte-wide, 1-cycle-latency memory port.
// Assembles four little-endian bytes into one instruction and holds it at the IF/ID boundary.
module if_byte_fetch #(
  parameter int unsigned          ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_busy_i,
  input  logic [7:0]        mem_din_i,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic              mem_rd_en_o,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [31:0]       if_inst_o,
  output logic              if_valid_o
);

  localparam int unsigned    CNT_W  = 3;
  localparam logic [CNT_W-1:0] N_BYTES = 3'd4;
  localparam logic [CNT_W-1:0] LAST_B  = 3'd3;

  typedef enum logic {S_FETCH = 1'b0, S_HOLD = 1'b1} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [CNT_W-1:0]  r_iss, w_iss_nxt;
  logic [CNT_W-1:0]  r_rcv, w_rcv_nxt;
  logic [23:0]       r_buf, w_buf_nxt;
  logic [ADDR_W-1:0] w_a_nxt, w_if_pc_nxt;
  logic [31:0]       w_inst_nxt;
  logic              w_rd_en_nxt, w_valid_nxt;
  logic              w_capture, w_complete, w_issue;

  // A byte is on mem_din_i whenever a read strobe was driven in the previous cycle
  assign w_capture  = (r_state == S_FETCH) && mem_rd_en_o;
  assign w_complete = w_capture && (r_rcv == LAST_B);
  assign w_issue    = (r_state == S_FETCH) && (r_iss < N_BYTES) && !mem_busy_i;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_state_nxt;
  end

  // Next state; a redirect overrides everything
  always_comb begin
    w_state_nxt = r_state;
    if (branch_flag_i) begin
      w_state_nxt = S_FETCH;
    end else begin
      case (r_state)
        S_FETCH: if (w_complete) w_state_nxt = S_HOLD;
        S_HOLD:  if (!stall_i)   w_state_nxt = S_FETCH;
        default: w_state_nxt = S_FETCH;
      endcase
    end
  end

  // Next values of the datapath and registered outputs
  always_comb begin
    w_pc_nxt    = r_pc;
    w_iss_nxt   = r_iss;
    w_rcv_nxt   = r_rcv;
    w_buf_nxt   = r_buf;
    w_a_nxt     = mem_a_o;
    w_rd_en_nxt = 1'b0;
    w_if_pc_nxt = if_pc_o;
    w_inst_nxt  = if_inst_o;
    w_valid_nxt = if_valid_o;
    if (branch_flag_i) begin
      w_pc_nxt    = branch_target_i;
      w_iss_nxt   = '0;
      w_rcv_nxt   = '0;
      w_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_issue) begin
            w_rd_en_nxt = 1'b1;
            w_a_nxt     = r_pc + ADDR_W'(r_iss);
            w_iss_nxt   = r_iss + 3'd1;
          end
          if (w_capture) begin
            w_rcv_nxt = r_rcv + 3'd1;
            if (w_complete) begin
              w_inst_nxt  = {mem_din_i, r_buf};
              w_if_pc_nxt = r_pc;
              w_valid_nxt = 1'b1;
            end else begin
              w_buf_nxt[{r_rcv[1:0], 3'b000} +: 8] = mem_din_i;
            end
          end
        end
        S_HOLD: begin
          if (!stall_i) begin
            w_pc_nxt    = r_pc + ADDR_W'(4);
            w_iss_nxt   = '0;
            w_rcv_nxt   = '0;
            w_valid_nxt = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_iss       <= '0;
      r_rcv       <= '0;
      r_buf       <= '0;
      mem_a_o     <= '0;
      mem_rd_en_o <= 1'b0;
      if_pc_o     <= RESET_PC;
      if_inst_o   <= '0;
      if_valid_o  <= 1'b0;
    end else begin
      r_pc        <= w_pc_nxt;
      r_iss       <= w_iss_nxt;
      r_rcv       <= w_rcv_nxt;
      r_buf       <= w_buf_nxt;
      mem_a_o     <= w_a_nxt;
      mem_rd_en_o <= w_rd_en_nxt;
      if_pc_o     <= w_if_pc_nxt;
      if_inst_o   <= w_inst_nxt;
      if_valid_o  <= w_valid_nxt;
    end
  end

endmodule

// File: tb/tb_if_byte_fetch.sv
// Bench for if_byte_fetch: directed scenarios followed by randomized busy/stall traffic
// checked against a transaction-level model of the fetch stream.
module tb_if_byte_fetch;

  localparam int unsigned ADDR_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk, rst, mem_busy_i, stall_i, branch_flag_i;
  logic [7:0]  mem_din_i;
  logic [31:0] branch_target_i, mem_a_o, if_pc_o, if_inst_o;
  logic        mem_rd_en_o, if_valid_o;

  logic [7:0]  mem [0:511];
  int          n_checks = 0;
  int          n_pass   = 0;

  if_byte_fetch #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .mem_busy_i(mem_busy_i), .mem_din_i(mem_din_i),
    .mem_a_o(mem_a_o), .mem_rd_en_o(mem_rd_en_o), .stall_i(stall_i),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .if_pc_o(if_pc_o), .if_inst_o(if_inst_o), .if_valid_o(if_valid_o)
  );

  // Memory answers the address strobed in the current cycle; garbage otherwise
  assign mem_din_i = mem_rd_en_o ? mem[mem_a_o[8:0]] : 8'hA5;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_inst(input logic [31:0] pc);
    logic [31:0] r;
    logic [31:0] a;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      a = pc + 32'(i);
      r[8*i +: 8] = mem[a[8:0]];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Undisturbed fetch: reads pc..pc+3 on four edges, valid on the fifth
  task automatic expect_fetch(input logic [31:0] pc, input string tag);
    for (int i = 0; i < 4; i++) begin
      tick();
      check({tag, "_rden"}, 32'(mem_rd_en_o), 32'd1);
      check({tag, "_addr"}, mem_a_o, pc + 32'(i));
    end
    tick();
    check({tag, "_valid"}, 32'(if_valid_o), 32'd1);
    check({tag, "_inst"}, if_inst_o, exp_inst(pc));
    check({tag, "_pc"}, if_pc_o, pc);
  endtask

  task automatic consume(input string tag);
    stall_i = 1'b0;
    tick();
    check({tag, "_cons_valid"}, 32'(if_valid_o), 32'd0);
    check({tag, "_cons_rden"}, 32'(mem_rd_en_o), 32'd0);
    stall_i = 1'b1;
  endtask

  initial begin
    logic [31:0] pc;
    logic [31:0] held_inst;
    int          reads, last_rd, hit, nstall;
    bit          b, done;

    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;
    mem_busy_i = 1'b0; stall_i = 1'b0; branch_flag_i = 1'b0; branch_target_i = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_valid", 32'(if_valid_o), 32'd0);
    check("rst_pc", if_pc_o, RESET_PC);
    check("rst_inst", if_inst_o, 32'h0);
    check("rst_rden", 32'(mem_rd_en_o), 32'd0);
    check("rst_addr", mem_a_o, 32'h0);
    tick(); tick();
    @(negedge clk) rst = 1'b0;

    // 1: basic fetch with stall low; consumed on the very next edge
    expect_fetch(32'h0, "t1");
    check("t1_inst_lit", if_inst_o, 32'h0010_0513);
    tick();
    check("t1_cons_valid", 32'(if_valid_o), 32'd0);
    check("t1_cons_rden", 32'(mem_rd_en_o), 32'd0);
    stall_i = 1'b1;
    tick();
    check("t1_next_addr", mem_a_o, 32'h4);
    check("t1_next_rden", 32'(mem_rd_en_o), 32'd1);

    // 2: busy for 3 cycles right after the byte-1 issue
    tick();
    check("t2_b1_addr", mem_a_o, 32'h5);
    mem_busy_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_busy_rden", 32'(mem_rd_en_o), 32'd0);
      check("t2_busy_valid", 32'(if_valid_o), 32'd0);
    end
    mem_busy_i = 1'b0;
    tick();
    check("t2_resume_addr", mem_a_o, 32'h6);
    tick();
    check("t2_b3_addr", mem_a_o, 32'h7);
    tick();
    check("t2_valid", 32'(if_valid_o), 32'd1);
    check("t2_inst", if_inst_o, exp_inst(32'h4));
    check("t2_pc", if_pc_o, 32'h4);
    consume("t2");

    // 3: stall 4 cycles in HOLD at pc=8
    expect_fetch(32'h8, "t3");
    held_inst = exp_inst(32'h8);
    for (int i = 0; i < 4; i++) begin
      mem_busy_i = 1'(i & 1);
      tick();
      check("t3_hold_pc", if_pc_o, 32'h8);
      check("t3_hold_inst", if_inst_o, held_inst);
      check("t3_hold_rden", 32'(mem_rd_en_o), 32'd0);
    end
    mem_busy_i = 1'b0;
    consume("t3");
    tick();
    check("t3_next_addr", mem_a_o, 32'hC);

    // 4: redirect while byte 2 is in flight
    tick(); tick();
    check("t4_b2_addr", mem_a_o, 32'hE);
    branch_flag_i = 1'b1; branch_target_i = 32'h100;
    tick();
    branch_flag_i = 1'b0;
    check("t4_redir_rden", 32'(mem_rd_en_o), 32'd0);
    check("t4_redir_valid", 32'(if_valid_o), 32'd0);
    expect_fetch(32'h100, "t4");
    consume("t4");

    // 5: redirect on the completion edge
    for (int i = 0; i < 4; i++) tick();
    check("t5_b3_addr", mem_a_o, 32'h107);
    branch_flag_i = 1'b1; branch_target_i = 32'h20;
    tick();
    branch_flag_i = 1'b0;
    check("t5_drop_valid", 32'(if_valid_o), 32'd0);
    check("t5_drop_rden", 32'(mem_rd_en_o), 32'd0);
    expect_fetch(32'h20, "t5");
    consume("t5");

    // 6: asynchronous reset mid-fetch
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    check("t6_rden", 32'(mem_rd_en_o), 32'd0);
    check("t6_valid", 32'(if_valid_o), 32'd0);
    check("t6_pc", if_pc_o, RESET_PC);
    @(negedge clk) rst = 1'b0;
    expect_fetch(RESET_PC, "t6");

    // Redirect from HOLD while stalled drops the held instruction; target near wrap
    branch_flag_i = 1'b1; branch_target_i = 32'hFFFF_FFFE;
    tick();
    branch_flag_i = 1'b0;
    check("hold_redir_valid", 32'(if_valid_o), 32'd0);

    // Randomized busy/stall: model is the sequential pc stream with four in-order byte reads
    pc = 32'hFFFF_FFFE;
    for (int n = 0; n < 40; n++) begin
      reads = 0; last_rd = -10; hit = -1; done = 1'b0;
      for (int c = 0; c < 60 && !done; c++) begin
        b = ($urandom_range(0, 2) == 0);
        mem_busy_i = b;
        tick();
        if (mem_rd_en_o) begin
          check("rnd_addr", mem_a_o, pc + 32'(reads));
          check("rnd_read_while_busy", 32'(b), 32'd0);
          reads++;
          last_rd = c;
        end
        if (if_valid_o) begin
          done = 1'b1;
          hit = c;
        end
      end
      mem_busy_i = 1'b0;
      check("rnd_valid", 32'(if_valid_o), 32'd1);
      check("rnd_reads", 32'(reads), 32'd4);
      check("rnd_latency", 32'(hit), 32'(last_rd + 1));
      check("rnd_pc", if_pc_o, pc);
      check("rnd_inst", if_inst_o, exp_inst(pc));
      nstall = $urandom_range(0, 3);
      for (int s = 0; s < nstall; s++) begin
        mem_busy_i = 1'($urandom_range(0, 1));
        tick();
        check("rnd_hold_pc", if_pc_o, pc);
        check("rnd_hold_inst", if_inst_o, exp_inst(pc));
        check("rnd_hold_rden", 32'(mem_rd_en_o), 32'd0);
      end
      mem_busy_i = 1'b0;
      consume("rnd");
      pc = pc + 32'd4;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
